// File: rtl/ex_cond_stage_pkg.sv
// Shared constants and payload types for the execute-stage condition unit.
package ex_cond_stage_pkg;

  localparam int unsigned ALUCTL_W = 5;

  localparam int unsigned N_BIT = 3;
  localparam int unsigned Z_BIT = 2;
  localparam int unsigned C_BIT = 1;
  localparam int unsigned V_BIT = 0;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Single-bit decode controls carried from D into E.
  typedef struct packed {
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       memtoreg;
    logic       branch;
    logic       alusrc;
    logic       nowrite;
    logic [1:0] flagw;
  } ctl_t;

endpackage

// File: rtl/ex_cond_stage_cond_check.sv
// Combinational condition-code evaluator: maps {cond, NZCV} to a pass bit.
module ex_cond_stage_cond_check
  import ex_cond_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass_c
);

  logic n, z, c, v;

  assign n = flags[N_BIT];
  assign z = flags[Z_BIT];
  assign c = flags[C_BIT];
  assign v = flags[V_BIT];

  always_comb begin
    pass_c = 1'b0;
    case (cond)
      COND_EQ: pass_c = z;
      COND_NE: pass_c = ~z;
      COND_CS: pass_c = c;
      COND_CC: pass_c = ~c;
      COND_MI: pass_c = n;
      COND_PL: pass_c = ~n;
      COND_VS: pass_c = v;
      COND_VC: pass_c = ~v;
      COND_HI: pass_c = c & ~z;
      COND_LS: pass_c = ~c | z;
      COND_GE: pass_c = (n == v);
      COND_LT: pass_c = (n != v);
      COND_GT: pass_c = ~z & (n == v);
      COND_LE: pass_c = z | (n != v);
      COND_AL: pass_c = 1'b1;
      default: pass_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_cond_stage.sv
// D->E pipeline register, NZCV flag register and condition-gated E-stage strobes.
module ex_cond_stage #(
  parameter int unsigned ALUCTL_W = ex_cond_stage_pkg::ALUCTL_W,
  parameter int unsigned RA_W     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                StallE,
  input  logic                FlushE,
  input  logic                PCSD,
  input  logic                RegWD,
  input  logic                MemWD,
  input  logic                MemtoRegD,
  input  logic                BranchD,
  input  logic                ALUSrcD,
  input  logic                NoWriteD,
  input  logic [1:0]          FlagWD,
  input  logic [ALUCTL_W-1:0] ALUControlD,
  input  logic [3:0]          CondD,
  input  logic [RA_W-1:0]     WA3D,
  input  logic [3:0]          ALUFlags,
  output logic                ValidE,
  output logic                CondExE,
  output logic                PCSrcE,
  output logic                RegWriteE,
  output logic                MemWriteE,
  output logic                BranchTakenE,
  output logic                MemtoRegE,
  output logic                ALUSrcE,
  output logic [ALUCTL_W-1:0] ALUControlE,
  output logic [RA_W-1:0]     WA3E,
  output logic [3:0]          FlagsE
);

  import ex_cond_stage_pkg::*;

  ctl_t                ctl_q;
  ctl_t                ctl_d;
  logic                valid_q;
  logic [3:0]          cond_q;
  logic [ALUCTL_W-1:0] aluctl_q;
  logic [RA_W-1:0]     wa3_q;
  logic [3:0]          flags_q;
  logic                cond_pass_c;
  logic                cond_ex_c;

  assign ctl_d = '{pcs:      PCSD,
                   regw:     RegWD,
                   memw:     MemWD,
                   memtoreg: MemtoRegD,
                   branch:   BranchD,
                   alusrc:   ALUSrcD,
                   nowrite:  NoWriteD,
                   flagw:    FlagWD};

  // E-stage register: reset > flush (bubble with AL cond) > stall (hold) > load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctl_q    <= '0;
      valid_q  <= 1'b0;
      cond_q   <= '0;
      aluctl_q <= '0;
      wa3_q    <= '0;
    end else if (FlushE) begin
      ctl_q    <= '0;
      valid_q  <= 1'b0;
      cond_q   <= COND_AL;
      aluctl_q <= '0;
      wa3_q    <= '0;
    end else if (!StallE) begin
      ctl_q    <= ctl_d;
      valid_q  <= 1'b1;
      cond_q   <= CondD;
      aluctl_q <= ALUControlD;
      wa3_q    <= WA3D;
    end
  end

  ex_cond_stage_cond_check u_cond_check (
    .cond   (cond_q),
    .flags  (flags_q),
    .pass_c (cond_pass_c)
  );

  assign cond_ex_c = cond_pass_c & valid_q;

  // Flags commit as the E instruction leaves; a flush at the same edge does not cancel it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q <= '0;
    end else begin
      if (ctl_q.flagw[1] && cond_ex_c && !StallE) flags_q[3:2] <= ALUFlags[3:2];
      if (ctl_q.flagw[0] && cond_ex_c && !StallE) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  assign ValidE       = valid_q;
  assign CondExE      = cond_ex_c;
  assign PCSrcE       = ctl_q.pcs & cond_ex_c;
  assign RegWriteE    = ctl_q.regw & ~ctl_q.nowrite & cond_ex_c;
  assign MemWriteE    = ctl_q.memw & cond_ex_c;
  assign BranchTakenE = ctl_q.branch & cond_ex_c;
  assign MemtoRegE    = ctl_q.memtoreg;
  assign ALUSrcE      = ctl_q.alusrc;
  assign ALUControlE  = aluctl_q;
  assign WA3E         = wa3_q;
  assign FlagsE       = flags_q;

endmodule

// File: doc/ex_cond_stage.md
Name: ex_cond_stage

Overview:
- Decode-to-execute pipeline register plus execute-stage conditional-execution unit for the pipelined ARM-subset core.
- Latches the decoder's control outputs and the instruction's condition field and destination register on each clock.
- Holds the architectural NZCV flag register and evaluates the condition against it.
- Produces the gated write, branch and PC-source strobes consumed by the EX/MEM register and the fetch stage.

Parameters:
- ALUCTL_W, 5, width of the ALU control field from decode.
- RA_W, 4, register address width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low: 0 = reset, sampled on the rising clk edge.
- StallE  input  1  hold all E-stage registers (hazard unit).
- FlushE  input  1  load a bubble into the E stage (hazard unit).
- PCSD  input  1  decode PC-write request.
- RegWD  input  1  decode register-write request.
- MemWD  input  1  decode memory-write request.
- MemtoRegD  input  1  load-result select.
- BranchD  input  1  branch instruction.
- ALUSrcD  input  1  immediate operand select.
- NoWriteD  input  1  compare/test op: suppress the register write.
- FlagWD  input  2  flag-write enables: [1] = NZ, [0] = CV.
- ALUControlD  input  ALUCTL_W  ALU operation.
- CondD  input  4  instruction bits [31:28].
- WA3D  input  RA_W  destination register.
- ALUFlags  input  4  NZCV from the ALU, combinational, for the instruction currently in E.
- ValidE  output  1  E stage holds a real instruction.
- CondExE  output  1  condition passed and ValidE.
- PCSrcE  output  1  PCSE & CondExE.
- RegWriteE  output  1  RegWE & ~NoWriteE & CondExE.
- MemWriteE  output  1  MemWE & CondExE.
- BranchTakenE  output  1  BranchE & CondExE.
- MemtoRegE  output  1  registered copy.
- ALUSrcE  output  1  registered copy.
- ALUControlE  output  ALUCTL_W  registered copy.
- WA3E  output  RA_W  registered copy.
- FlagsE  output  4  current NZCV register value {N,Z,C,V}.

Behaviour:
- Reset (reset=0 at a clock edge):
  - All E registers go to 0, including ValidE.
  - Flags go to 4'b0000.
  - All outputs are therefore 0 one cycle later; a reset takes priority over stall and flush.
- Per edge, with reset=1, exactly one of the following applies:
  - FlushE=1: bubble. All control registers go to 0, ValidE=0, and CondE goes to 4'b1110. Flush wins over stall.
  - FlushE=0 and StallE=1: all E registers hold their value.
  - Otherwise: load the D-side inputs and set ValidE=1.
- Latency: a decode bundle presented in cycle t appears on the E outputs in cycle t+1.
- Condition evaluation is combinational on CondE and the registered flags (N, Z, C, V):
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C & ~Z
  - 1001 LS: ~C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: ~Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111: 0 (reserved, never executes)
- Flag update, on the edge that ends the E cycle:
  - Flags[3:2] <= ALUFlags[3:2] when FlagWE[1] & CondExE & ~StallE.
  - Flags[1:0] <= ALUFlags[1:0] when FlagWE[0] & CondExE & ~StallE.
  - A failed or bubbled instruction never changes the flags.
- Flag timing: an instruction in E sees the flags written by the instruction that left E on the previous edge. There is no same-cycle bypass, because the previous instruction's write has already committed.
- Stall: while StallE=1, the gated outputs stay stable and keep their value. Downstream uses StallE to avoid double commit. Flags are not written while stalled, so a stall cannot double-apply an update.
- Simultaneous FlushE and flag write: the flag write for the departing E instruction still commits, since it is gated by the current-cycle CondExE. The bubble is loaded at the same edge.

Decomposition:
- Shared package holds:
  - the condition-code constants COND_EQ through COND_AL and COND_NV;
  - the flag bit indices N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0;
  - ALUCTL_W.
- One sub-module, cond_check: a purely combinational map from CondE and Flags to the pass bit.
- The pipeline register, flag register and output gating remain in ex_cond_stage.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all inputs at 1 → every output is 0 and FlagsE=0000. Release reset → the first bundle appears one cycle later with ValidE=1.
- Flag set, then conditional branch:
  - CMP bundle (FlagWD=11, NoWriteD=1, RegWD=1, CondD=1110, ALUFlags=0100) → RegWriteE=0, and FlagsE=0100 on the next cycle.
  - Next, a BEQ bundle (BranchD=1, PCSD=1, CondD=0000) → BranchTakenE=1 and PCSrcE=1.
- Failed condition:
  - Flags=0100, then ADD with CondD=0001 (NE), RegWD=1, FlagWD=11, ALUFlags=1001 → CondExE=0 and RegWriteE=0.
  - Flags remain 0100.
- Split flag write: FlagWD=10 with ALUFlags=1011 from Flags=0110 → Flags becomes 1010, with only N and Z changing.
- Stall then flush:
  - Load STR (MemWD=1, CondD=1110) → MemWriteE=1.
  - StallE=1 for 3 cycles → MemWriteE stays 1 and WA3E stays unchanged.
  - Assert FlushE and StallE together → the next cycle has ValidE=0 and all strobes at 0.
- Cond 1111 and signed compares:
  - CondD=1111 → CondExE=0 for any flag value.
  - Flags=1001 with GE → CondExE=1.
  - Flags=1000 with LT → CondExE=1.
  - Flags=0000 with GT → CondExE=1.
